// File: rtl/two_bit_product_pkg.sv
// Shared widths for the two-bit multiplier slice.
package two_bit_product_pkg;
    localparam int OPERAND_W     = 2;
    localparam int PRODUCT_W     = 4;
    localparam int CNT_W_DEFAULT = 8;
endpackage

// File: rtl/two_bit_product_half_adder.sv
// Single-bit half adder used to reduce the partial-product columns.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/two_bit_product.sv
// 2x2 unsigned array multiplier with a registered, valid-qualified result
// and a wrapping count of accepted operand pairs.
module two_bit_product
    import two_bit_product_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic                 in_valid,
    output logic [PRODUCT_W-1:0] res,
    output logic [PRODUCT_W-1:0] res_q,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     op_count
);
    logic                 pp00, pp01, pp10, pp11;
    logic                 sum1, c1, sum2, c2;
    logic [PRODUCT_W-1:0] res_p0;
    logic [PRODUCT_W-1:0] res_p1;
    logic                 vld_p1;
    logic [CNT_W-1:0]     cnt_p1;

    // Stage p0: partial products and column reduction, purely combinational
    always_comb begin
        pp00 = a[0] & b[0];
        pp10 = a[1] & b[0];
        pp01 = a[0] & b[1];
        pp11 = a[1] & b[1];
    end

    half_adder u_ha_col1 (
        .x (pp10),
        .y (pp01),
        .s (sum1),
        .c (c1)
    );

    half_adder u_ha_col2 (
        .x (pp11),
        .y (c1),
        .s (sum2),
        .c (c2)
    );

    assign res_p0 = {c2, sum2, sum1, pp00};
    assign res    = res_p0;

    // Stage p1: result register, valid flag and accepted-pair counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_p1 <= '0;
            vld_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                res_p1 <= res_p0;
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
        end
    end

    assign res_q     = res_p1;
    assign out_valid = vld_p1;
    assign op_count  = cnt_p1;
endmodule

// File: tb/tb_two_bit_product.sv
// Scoreboard bench: stimulus pushes expected products, a negedge monitor pops and checks.
module tb_two_bit_product;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       a;
    logic [1:0]       b;
    logic             in_valid;
    logic [3:0]       res;
    logic [3:0]       res_q;
    logic             out_valid;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int m_res_q = 0;
    int m_cnt   = 0;

    two_bit_product #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .res       (res),
        .res_q     (res_q),
        .out_valid (out_valid),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the reference model updates right after the edge.
    task automatic step(input logic r, input logic v, input int aa, input int bb);
        rst      = r;
        in_valid = v;
        a        = 2'(aa);
        b        = 2'(bb);
        #1;
        chk("res_comb", int'(res), aa * bb);
        @(posedge clk);
        if (!r) begin
            m_res_q = 0;
            m_cnt   = 0;
        end else if (v) begin
            m_res_q = aa * bb;
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
            exp_q.push_back(m_res_q);
        end
        #1;
    endtask

    // Monitor: every item pushed at an edge must appear as an out_valid pulse before the next edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("res_q_on_valid", int'(res_q), exp_q.pop_front());
            end
        end else begin
            chk("out_valid_expected", int'(out_valid === 1'b1), int'(exp_q.size() != 0));
            exp_q.delete();
        end
        chk("res_q_state", int'(res_q), m_res_q);
        chk("op_count", int'(op_count), m_cnt);
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0;

        // Reset dominates a valid 3*3 operand
        step(1'b0, 1'b1, 3, 3);
        step(1'b0, 1'b1, 3, 3);
        chk("rst_res", int'(res), 9);
        chk("rst_res_q", int'(res_q), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_op_count", int'(op_count), 0);

        // Exhaustive operand sweep, accepted back-to-back
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i / 4, i % 4);

        // Two consecutive pairs after a fresh reset
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 2, 2);
        step(1'b1, 1'b1, 1, 3);
        chk("seq_res_q", int'(res_q), 3);
        chk("seq_op_count", int'(op_count), 2);

        // Operand toggling without in_valid
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom_range(3), $urandom_range(3));
        chk("idle_res_q", int'(res_q), 3);
        chk("idle_op_count", int'(op_count), 2);

        // Reset one cycle after a valid pulse
        step(1'b1, 1'b1, 3, 2);
        step(1'b0, 1'b0, 1, 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_res_q", int'(res_q), 0);
        chk("midrst_op_count", int'(op_count), 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 2, 3);
        step(1'b1, 1'b0, 0, 0);

        // 256 accepted pairs wrap the counter back to the start
        step(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, $urandom_range(3), $urandom_range(3));
        chk("wrap_op_count", int'(op_count), 0);
        step(1'b1, 1'b1, 3, 3);
        chk("post_wrap_op_count", int'(op_count), 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            step(($urandom_range(19) != 0), $urandom_range(1) == 1,
                 $urandom_range(3), $urandom_range(3));

        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
